// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter sharing the data memory between the CPU LSU (A)
// and the debug loader (B), with a burst limit that bounds starvation.
module dmem_arbiter #(
  parameter int XLEN      = 32,
  parameter int MAX_BURST = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [XLEN-1:0] a_addr,
  input  logic [XLEN-1:0] a_wdata,
  input  logic [2:0]      a_type,
  output logic            a_gnt,
  output logic [XLEN-1:0] a_rdata,
  output logic            a_rvalid,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [XLEN-1:0] b_addr,
  input  logic [XLEN-1:0] b_wdata,
  input  logic [2:0]      b_type,
  output logic            b_gnt,
  output logic [XLEN-1:0] b_rdata,
  output logic            b_rvalid,
  output logic            mem_enable,
  output logic            mem_write_enable,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_data_in,
  output logic [2:0]      mem_type_select,
  input  logic [XLEN-1:0] mem_data_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // burst_cnt counts extra grants beyond the first in the current run
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [1:0] state, state_next;
  logic [3:0] burst_cnt, burst_cnt_next, burst_sat;
  logic       last_owner;

  assign burst_sat = (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;

  always_comb begin
    state_next     = IDLE;
    burst_cnt_next = 4'd0;
    case (state)
      IDLE: begin
        if (a_req && b_req)
          state_next = (last_owner == OWNER_B) ? OWN_A : OWN_B;
        else if (a_req)
          state_next = OWN_A;
        else if (b_req)
          state_next = OWN_B;
      end
      OWN_A: begin
        if (a_req && (!b_req || burst_cnt < BURST_LAST)) begin
          state_next     = OWN_A;
          burst_cnt_next = burst_sat;
        end else if (b_req) begin
          state_next = OWN_B;
        end else if (a_req) begin
          state_next     = OWN_A;
          burst_cnt_next = burst_sat;
        end
      end
      OWN_B: begin
        if (b_req && (!a_req || burst_cnt < BURST_LAST)) begin
          state_next     = OWN_B;
          burst_cnt_next = burst_sat;
        end else if (a_req) begin
          state_next = OWN_A;
        end else if (b_req) begin
          state_next     = OWN_B;
          burst_cnt_next = burst_sat;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // last_owner starts at B so that A wins the very first tie
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      burst_cnt  <= 4'd0;
      last_owner <= OWNER_B;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_cnt_next;
      if (state == OWN_A)
        last_owner <= OWNER_A;
      else if (state == OWN_B)
        last_owner <= OWNER_B;
    end
  end

  assign a_gnt = (state == OWN_A) && a_req;
  assign b_gnt = (state == OWN_B) && b_req;

  always_comb begin
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    mem_type_select  = 3'd0;
    if (a_gnt) begin
      mem_enable       = 1'b1;
      mem_write_enable = a_we;
      mem_address      = a_addr;
      mem_data_in      = a_wdata;
      mem_type_select  = a_type;
    end else if (b_gnt) begin
      mem_enable       = 1'b1;
      mem_write_enable = b_we;
      mem_address      = b_addr;
      mem_data_in      = b_wdata;
      mem_type_select  = b_type;
    end
  end

  // Read data is captured at the edge ending the grant cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we)
        a_rdata <= mem_data_out;
      if (b_gnt && !b_we)
        b_rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner cases,
// and randomized traffic against a run-length based arbitration model.
module tb_dmem_arbiter;

  localparam int XLEN      = 32;
  localparam int MAX_BURST = 4;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            a_req, a_we, b_req, b_we;
  logic [XLEN-1:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [2:0]      a_type, b_type;
  logic            a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [XLEN-1:0] a_rdata, b_rdata;
  logic            mem_enable, mem_write_enable;
  logic [XLEN-1:0] mem_address, mem_data_in, mem_data_out;
  logic [2:0]      mem_type_select;

  logic [31:0] memArr [0:15];
  logic        memInit = 1'b0;

  int assertCount = 0;
  int failCount   = 0;

  dmem_arbiter #(.XLEN(XLEN), .MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_type(a_type),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_type(b_type),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_type_select(mem_type_select), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  // Word-granular memory stand-in: combinational read, write at the clock edge
  assign mem_data_out = memArr[mem_address[5:2]];

  always @(posedge clock or posedge memInit) begin
    if (memInit) begin
      for (int i = 0; i < 16; i++) memArr[i] <= 32'h0101_0101 * i + 32'h0000_1100;
    end else if (mem_enable && mem_write_enable) begin
      memArr[mem_address[5:2]] <= mem_data_in;
    end
  end

  typedef struct {
    logic aReq, bReq, aWe, bWe;
    logic expA, expB;
  } vec_t;

  vec_t vecs [17];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                               input logic [2:0] at, input logic br, input logic bw, input logic [31:0] ba,
                               input logic [31:0] bd, input logic [2:0] bt);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad; a_type = at;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_type = bt;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset_n = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 3'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_a_gnt"}, 32'(a_gnt), 32'h0);
    checkOutput({tag, "_b_gnt"}, 32'(b_gnt), 32'h0);
    checkOutput({tag, "_a_rvalid"}, 32'(a_rvalid), 32'h0);
    checkOutput({tag, "_b_rvalid"}, 32'(b_rvalid), 32'h0);
    checkOutput({tag, "_a_rdata"}, a_rdata, 32'h0);
    checkOutput({tag, "_b_rdata"}, b_rdata, 32'h0);
    checkOutput({tag, "_mem_enable"}, 32'(mem_enable), 32'h0);
    checkOutput({tag, "_mem_we"}, 32'(mem_write_enable), 32'h0);
    checkOutput({tag, "_mem_addr"}, mem_address, 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_data_in, 32'h0);
    checkOutput({tag, "_mem_type"}, 32'(mem_type_select), 32'h0);
  endtask

  logic found;
  int   owner, runLen, lastOwner, bProb;
  logic expAGnt, expBGnt, nxtARvalid, nxtBRvalid, expARvalid, expBRvalid;
  logic [31:0] expARdata, expBRdata, nxtARdata, nxtBRdata;

  initial begin
    reset_n = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 3'd0);
    #1 memInit = 1'b1;
    #1 memInit = 1'b0;

    // Reset with both requests high: every output quiet, A wins first tie
    @(negedge clock);
    reset_n = 1'b0;
    applyStimulus(1, 1, 32'h1000_0030, 32'h1234_5678, 3'd2, 1, 1, 32'h1000_0034, 32'h8765_4321, 3'd3);
    #1 checkAllZero("rst");
    repeat (2) @(negedge clock);
    #1 checkAllZero("rstHold");
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1, 0, 32'h1000_0030, 32'h1234_5678, 3'd2, 1, 0, 32'h1000_0034, 32'h8765_4321, 3'd3);
    @(negedge clock); #1;
    checkOutput("rstRelease_a_gnt", 32'(a_gnt), 32'h1);
    checkOutput("rstRelease_b_gnt", 32'(b_gnt), 32'h0);

    // Vector table: burst limit, withdrawal and round-robin tie from IDLE
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    doReset();
    for (int v = 0; v < 17; v++) begin
      @(negedge clock);
      applyStimulus(vecs[v].aReq, vecs[v].aWe, 32'h1000_0010, 32'hA5A5_0001, 3'd1,
                    vecs[v].bReq, vecs[v].bWe, 32'h1000_0020, 32'h5A5A_0002, 3'd2);
      #1;
      checkOutput($sformatf("vec%0d_a_gnt", v), 32'(a_gnt), 32'(vecs[v].expA));
      checkOutput($sformatf("vec%0d_b_gnt", v), 32'(b_gnt), 32'(vecs[v].expB));
      checkOutput($sformatf("vec%0d_mem_en", v), 32'(mem_enable), 32'(vecs[v].expA | vecs[v].expB));
      checkOutput($sformatf("vec%0d_mem_we", v), 32'(mem_write_enable),
                  32'((vecs[v].expA & vecs[v].aWe) | (vecs[v].expB & vecs[v].bWe)));
      checkOutput($sformatf("vec%0d_mem_addr", v), mem_address,
                  vecs[v].expA ? 32'h1000_0010 : (vecs[v].expB ? 32'h1000_0020 : 32'h0));
    end

    // Port A write then read of the same word
    doReset();
    @(posedge clock); #1;
    applyStimulus(1, 1, 32'h1000_0004, 32'hDEAD_BEEF, 3'd2, 0, 0, 32'h0, 32'h0, 3'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock); #1;
      if (a_gnt) found = 1'b1;
    end
    checkOutput("wr_grantSeen", 32'(found), 32'h1);
    checkOutput("wr_mem_we", 32'(mem_write_enable), 32'h1);
    checkOutput("wr_mem_addr", mem_address, 32'h1000_0004);
    checkOutput("wr_mem_wdata", mem_data_in, 32'hDEAD_BEEF);
    checkOutput("wr_mem_type", 32'(mem_type_select), 32'h2);
    @(posedge clock); #1;
    a_req = 1'b0;
    @(negedge clock); #1;
    checkOutput("withdrawn_a_gnt", 32'(a_gnt), 32'h0);
    checkOutput("withdrawn_mem_en", 32'(mem_enable), 32'h0);
    @(posedge clock); #1;
    checkOutput("withdrawn_a_rvalid", 32'(a_rvalid), 32'h0);
    applyStimulus(1, 0, 32'h1000_0004, 32'h0, 3'd2, 0, 0, 32'h0, 32'h0, 3'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock); #1;
      if (a_gnt) found = 1'b1;
    end
    checkOutput("rd_grantSeen", 32'(found), 32'h1);
    checkOutput("rd_mem_we", 32'(mem_write_enable), 32'h0);
    checkOutput("rd_a_rvalid_during_gnt", 32'(a_rvalid), 32'h0);
    @(posedge clock); #1;
    a_req = 1'b0;
    checkOutput("rd_a_rvalid", 32'(a_rvalid), 32'h1);
    checkOutput("rd_a_rdata", a_rdata, 32'hDEAD_BEEF);
    @(posedge clock); #1;
    checkOutput("rd_a_rvalid_pulse", 32'(a_rvalid), 32'h0);
    checkOutput("rd_a_rdata_hold", a_rdata, 32'hDEAD_BEEF);

    // Asynchronous reset during a port B read grant
    doReset();
    @(posedge clock); #1;
    applyStimulus(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 32'h1000_0008, 32'h0, 3'd2);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock); #1;
      if (b_gnt) found = 1'b1;
    end
    checkOutput("rstRd_grantSeen", 32'(found), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rstRd_mem_en", 32'(mem_enable), 32'h0);
    checkOutput("rstRd_b_gnt", 32'(b_gnt), 32'h0);
    @(posedge clock); #1;
    checkOutput("rstRd_b_rvalid", 32'(b_rvalid), 32'h0);
    checkOutput("rstRd_b_rdata", b_rdata, 32'h0);
    @(posedge clock); #1;
    checkOutput("rstRd_b_rvalid2", 32'(b_rvalid), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    b_req = 1'b0;

    // Randomized traffic against a run-length arbitration model
    doReset();
    owner = 0; runLen = 0; lastOwner = 2;
    expARvalid = 1'b0; expBRvalid = 1'b0; expARdata = 32'h0; expBRdata = 32'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bProb = (cyc >= 200 && cyc < 320) ? 1 : 12;
      @(negedge clock);
      applyStimulus(1'($urandom_range(0, 15) < 12), 1'($urandom_range(0, 1)),
                    32'h1000_0000 | (32'($urandom_range(0, 15)) << 2), $urandom, 3'($urandom_range(0, 4)),
                    1'($urandom_range(0, 15) < bProb), 1'($urandom_range(0, 1)),
                    32'h1000_0000 | (32'($urandom_range(0, 15)) << 2), $urandom, 3'($urandom_range(0, 4)));
      #1;
      expAGnt = (owner == 1) && a_req;
      expBGnt = (owner == 2) && b_req;
      checkOutput("rnd_a_gnt", 32'(a_gnt), 32'(expAGnt));
      checkOutput("rnd_b_gnt", 32'(b_gnt), 32'(expBGnt));
      checkOutput("rnd_mem_en", 32'(mem_enable), 32'(expAGnt | expBGnt));
      checkOutput("rnd_mem_we", 32'(mem_write_enable), 32'((expAGnt & a_we) | (expBGnt & b_we)));
      checkOutput("rnd_mem_addr", mem_address, expAGnt ? a_addr : (expBGnt ? b_addr : 32'h0));
      checkOutput("rnd_mem_wdata", mem_data_in, expAGnt ? a_wdata : (expBGnt ? b_wdata : 32'h0));
      checkOutput("rnd_mem_type", 32'(mem_type_select), 32'(expAGnt ? a_type : (expBGnt ? b_type : 3'd0)));
      checkOutput("rnd_a_rvalid", 32'(a_rvalid), 32'(expARvalid));
      checkOutput("rnd_b_rvalid", 32'(b_rvalid), 32'(expBRvalid));
      checkOutput("rnd_a_rdata", a_rdata, expARdata);
      checkOutput("rnd_b_rdata", b_rdata, expBRdata);

      nxtARvalid = expAGnt && !a_we;
      nxtBRvalid = expBGnt && !b_we;
      nxtARdata  = nxtARvalid ? memArr[a_addr[5:2]] : expARdata;
      nxtBRdata  = nxtBRvalid ? memArr[b_addr[5:2]] : expBRdata;

      if (owner == 0) begin
        if (a_req && b_req) owner = (lastOwner == 1) ? 2 : 1;
        else if (a_req)     owner = 1;
        else if (b_req)     owner = 2;
        runLen = 1;
      end else if (owner == 1) begin
        lastOwner = 1;
        if (a_req && (!b_req || runLen < MAX_BURST)) runLen++;
        else if (b_req) begin owner = 2; runLen = 1; end
        else owner = 0;
      end else begin
        lastOwner = 2;
        if (b_req && (!a_req || runLen < MAX_BURST)) runLen++;
        else if (a_req) begin owner = 1; runLen = 1; end
        else owner = 0;
      end

      @(posedge clock);
      expARvalid = nxtARvalid; expBRvalid = nxtBRvalid;
      expARdata  = nxtARdata;  expBRdata  = nxtBRdata;
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single-port data memory / MMIO block between the CPU load-store unit (port A) and the debug/program-loader port (port B). It registers the grant decision and drives the memory's enable, write-enable, address, write-data and access-type inputs from the owning requester. It also registers read data back to that requester. It applies round-robin priority, with a burst limit that bounds starvation.

Parameters:
XLEN, 32, data and address width; matches the memory block.
MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting; legal range 1..15.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
a_req  input  1  port A access request; held with its payload until a_gnt.
a_we  input  1  port A write (1) / read (0).
a_addr  input  XLEN  port A byte address.
a_wdata  input  XLEN  port A write data.
a_type  input  3  port A access type (WORD/HALF_WORD/BYTE/HALF_WORDU/BYTEU codes).
a_gnt  output  1  port A access performed this cycle.
a_rdata  output  XLEN  port A registered read data.
a_rvalid  output  1  a_rdata valid, one-cycle pulse.
b_req, b_we, b_addr, b_wdata, b_type, b_gnt, b_rdata, b_rvalid  as port A, for port B.
mem_enable  output  1  to memory enable.
mem_write_enable  output  1  to memory write_enable.
mem_address  output  XLEN  to memory address.
mem_data_in  output  XLEN  to memory data_in.
mem_type_select  output  3  to memory Type_Select.
mem_data_out  input  XLEN  combinational read data from memory.

Behaviour:
- Single clock domain, `clock`. Reset is asynchronous and active-low on `reset_n`.
- Reset drives state=IDLE, burst_cnt=0, last_owner=B (so A wins the first tie).
- Reset also drives every output to 0: a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata and all mem_* outputs.
- A reset asserted mid-access aborts it: no write is committed after reset falls, no rvalid is produced, and pending requests are re-arbitrated after reset release.
- FSM states: IDLE, OWN_A, OWN_B, held in a registered state. Next state is computed from the a_req/b_req values sampled at each rising edge.
- From IDLE:
  - a_req only -> OWN_A.
  - b_req only -> OWN_B.
  - Both -> the port that is not last_owner.
  - Neither -> IDLE.
- From OWN_A:
  - a_req && (!b_req || burst_cnt < MAX_BURST-1) -> OWN_A, burst_cnt+1.
  - Otherwise b_req -> OWN_B, burst_cnt=0.
  - Otherwise a_req -> OWN_A. burst_cnt saturates; the limit only applies while B is waiting.
  - Otherwise -> IDLE.
- OWN_B is symmetric.
- last_owner updates to the owning port on every OWN_x cycle.
- Grant (combinational from registered state):
  - a_gnt = (state==OWN_A) && a_req; b_gnt likewise for OWN_B.
  - A request withdrawn in the owning cycle gets no grant and no memory access.
- Memory drive:
  - When x_gnt=1: mem_enable=1, mem_write_enable=x_we, and mem_address/mem_data_in/mem_type_select = port x payload.
  - When no grant: mem_enable=0, mem_write_enable=0, other mem_* outputs held at 0.
  - At most one port is ever driven.
- Latency: request seen at edge N -> grant cycle N+1 (earliest) -> the access commits at the edge ending that cycle.
- Read return: if the grant was a read, x_rdata <= mem_data_out at the edge ending the grant cycle, and x_rvalid=1 for exactly the following cycle.
  - x_rdata holds its value until the next read for that port.
  - Writes produce no rvalid.
- Back-to-back: a requester that keeps req high after a gnt cycle issues a new access. With payload changed at the gnt edge, it receives a grant every cycle (throughput 1 access/cycle) subject to the burst limit.
- Ports are independent: rvalid for A may coincide with b_gnt.

Test Plan:
- Reset: hold reset_n=0 with a_req=b_req=1 -> all outputs 0. Release -> a_gnt=1 two edges later (first-tie rule), b_gnt=0.
- Single write then read, port A: a_we=1, addr 0x10000004, wdata 0xDEADBEEF, type WORD -> one a_gnt cycle with mem_write_enable=1. Then read of the same address -> a_rdata=0xDEADBEEF with a_rvalid high for exactly 1 cycle, one cycle after a_gnt.
- Burst limit: both ports request continuously, MAX_BURST=4 -> grant pattern A,A,A,A,B,B,B,B,A,... Never more than 4 consecutive grants to one port.
- Round-robin tie from IDLE: A served last, both raise req in the same cycle -> B granted first.
- Withdrawn request: a_req drops in the OWN_A cycle -> a_gnt=0, mem_enable=0, no a_rvalid, FSM to IDLE or OWN_B.
- Async reset mid-read: reset_n falls during b_gnt cycle, before the edge -> b_rvalid never asserts, b_rdata=0, mem_enable=0 immediately.
